// File: rtl/matrix_pkg.sv
// Shared constants, scan-state encoding and row-select helpers for the LED matrix scanner.
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int PTR_W = 3;

    // Two-hot-free encoding so that 2'b00 and 2'b11 are detectably illegal.
    typedef enum logic [1:0] {
        BLANK = 2'b01,
        SHOW  = 2'b10
    } scan_state_t;

    function automatic logic [ROWS-1:0] row_idle(input bit active_low);
        return active_low ? {ROWS{1'b1}} : {ROWS{1'b0}};
    endfunction

    function automatic logic [ROWS-1:0] row_select(input bit active_low,
                                                   input logic [PTR_W-1:0] ptr);
        logic [ROWS-1:0] onehot;
        onehot = ROWS'(1) << ptr;
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/row_buffer.sv
// 8x8 row register file: one write port with clear, a registered read port and a
// combinational tap that the scanner snapshots once per slot.
module row_buffer
    import matrix_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [PTR_W-1:0]   wr_idx_i,
    input  logic [COLS-1:0]    wr_data_i,
    input  logic               clear_i,
    input  logic [PTR_W-1:0]   rd_idx_i,
    output logic [COLS-1:0]    rd_data_o,
    input  logic [PTR_W-1:0]   scan_idx_i,
    output logic [COLS-1:0]    scan_data_o
);

    logic [ROWS-1:0][COLS-1:0] rows_flat;
    logic [COLS-1:0]           rd_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] row_q;

            // Clear wins over a write landing in the same cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    row_q <= '0;
                end else if (clear_i) begin
                    row_q <= '0;
                end else if (wr_en_i && (wr_idx_i == PTR_W'(gi))) begin
                    row_q <= wr_data_i;
                end
            end

            assign rows_flat[gi] = row_q;
        end
    endgenerate

    // Reads the pre-write contents, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rows_flat[rd_idx_i];
        end
    end

    assign rd_data_o   = rd_data_q;
    assign scan_data_o = rows_flat[scan_idx_i];

endmodule

// File: rtl/matrix_scan.sv
// Row buffer plus a blank/show time-multiplexer driving an 8x8 LED matrix, one row
// per SCAN_DIV-cycle slot, with BLANK_CYCLES of all-rows-off at the start of each slot.
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic             sysClk,
    input  logic             resetN,
    input  logic [2:0]       wrIndex,
    input  logic [7:0]       wrData,
    input  logic             writeStrobe,
    input  logic             clearAll,
    input  logic [2:0]       rdIndex,
    output logic [7:0]       rowRead,
    output logic [7:0]       rowSel,
    output logic [7:0]       colData,
    output logic             frameTick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [ROWS-1:0]  ROW_IDLE   = row_idle(ROW_ACTIVE_LOW);

    scan_state_t        state_q;
    logic [PTR_W-1:0]   row_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ROWS-1:0]    row_sel_q;
    logic [COLS-1:0]    col_data_q;
    logic               frame_tick_q;
    logic [COLS-1:0]    scan_row;

    row_buffer u_row_buffer (
        .clk_i       (sysClk),
        .rst_ni      (resetN),
        .wr_en_i     (writeStrobe),
        .wr_idx_i    (wrIndex),
        .wr_data_i   (wrData),
        .clear_i     (clearAll),
        .rd_idx_i    (rdIndex),
        .rd_data_o   (rowRead),
        .scan_idx_i  (row_ptr_q),
        .scan_data_o (scan_row)
    );

    // cnt runs 0..SCAN_DIV-1 across the whole slot; BLANK owns the first BLANK_CYCLES counts.
    always_ff @(posedge sysClk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= BLANK;
            row_ptr_q    <= '0;
            cnt_q        <= '0;
            row_sel_q    <= ROW_IDLE;
            col_data_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            case (state_q)
                BLANK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_q    <= SHOW;
                        row_sel_q  <= row_select(ROW_ACTIVE_LOW, row_ptr_q);
                        col_data_q <= scan_row;
                    end else begin
                        row_sel_q  <= ROW_IDLE;
                        col_data_q <= '0;
                    end
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_q      <= BLANK;
                        cnt_q        <= '0;
                        row_ptr_q    <= row_ptr_q + 1'b1;
                        row_sel_q    <= ROW_IDLE;
                        col_data_q   <= '0;
                        frame_tick_q <= (row_ptr_q == PTR_W'(ROWS - 1));
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= BLANK;
                    row_ptr_q  <= '0;
                    cnt_q      <= '0;
                    row_sel_q  <= ROW_IDLE;
                    col_data_q <= '0;
                end
            endcase
        end
    end

    assign rowSel    = row_sel_q;
    assign colData   = col_data_q;
    assign frameTick = frame_tick_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with SCAN_DIV=10, BLANK_CYCLES=2, active-low row select.
module tb_matrix_scan;

    localparam int SCAN_DIV     = 10;
    localparam int BLANK_CYCLES = 2;

    logic       sysClk = 1'b0;
    logic       resetN = 1'b0;
    logic [2:0] wrIndex = '0;
    logic [7:0] wrData = '0;
    logic       writeStrobe = 1'b0;
    logic       clearAll = 1'b0;
    logic [2:0] rdIndex = '0;
    logic [7:0] rowRead;
    logic [7:0] rowSel;
    logic [7:0] colData;
    logic       frameTick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    matrix_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYCLES   (BLANK_CYCLES),
        .ROW_ACTIVE_LOW (1'b1)
    ) dut (
        .sysClk      (sysClk),
        .resetN      (resetN),
        .wrIndex     (wrIndex),
        .wrData      (wrData),
        .writeStrobe (writeStrobe),
        .clearAll    (clearAll),
        .rdIndex     (rdIndex),
        .rowRead     (rowRead),
        .rowSel      (rowSel),
        .colData     (colData),
        .frameTick   (frameTick)
    );

    always #5 sysClk = ~sysClk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge sysClk);
        @(negedge sysClk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [7:0] data);
        wrIndex     = idx;
        wrData      = data;
        writeStrobe = 1'b1;
        tick();
        writeStrobe = 1'b0;
        $display("cycle %0d: write row %0d = %02h", cyc, idx, data);
    endtask

    // Reference scan pattern: cycle c counts rising edges since reset release.
    function automatic logic [7:0] exp_sel(input int c);
        logic [7:0] onehot;
        int         row;
        row    = (c / SCAN_DIV) % 8;
        onehot = 8'(1) << row;
        return ((c % SCAN_DIV) >= BLANK_CYCLES) ? ~onehot : 8'hFF;
    endfunction

    function automatic logic exp_tick(input int c);
        return (c > 0) && ((c % (8 * SCAN_DIV)) == 0);
    endfunction

    initial begin
        int t5;
        int blank_run;
        logic prev_active;

        // Reset values
        repeat (3) @(negedge sysClk);
        check_eq("rst_rowSel", rowSel, 8'hFF);
        check_eq("rst_colData", colData, 8'h00);
        check_eq("rst_rowRead", rowRead, 8'h00);
        check_eq("rst_frameTick", frameTick, 1'b0);
        resetN = 1'b1;
        cyc    = 0;
        $display("cycle %0d: reset released", cyc);

        // 1: idle scan over one full frame plus the wrap cycle
        for (int i = 0; i < 81; i++) begin
            tick();
            check_eq("t1_rowSel", rowSel, exp_sel(cyc));
            check_eq("t1_colData", colData, 8'h00);
            check_eq("t1_frameTick", frameTick, exp_tick(cyc));
        end

        // 2: write row 3 and read it back, then see it on the matrix
        rdIndex = 3'd3;
        do_write(3'd3, 8'hE0);
        check_eq("t2_read_old", rowRead, 8'h00);
        tick();
        check_eq("t2_read_new", rowRead, 8'hE0);
        run_to(112);
        check_eq("t2_show_sel", rowSel, 8'hF7);
        check_eq("t2_show_col", colData, 8'hE0);

        // 3: mid-slot rewrite of the shown row must not disturb the snapshot
        run_to(115);
        do_write(3'd3, 8'h1C);
        while (cyc < 120) begin
            check_eq("t3_hold_col", colData, 8'hE0);
            check_eq("t3_hold_sel", rowSel, 8'hF7);
            tick();
        end
        check_eq("t3_blank_col", colData, 8'h00);
        check_eq("t3_blank_sel", rowSel, 8'hFF);
        run_to(192);
        check_eq("t3_next_col", colData, 8'h1C);
        check_eq("t3_next_sel", rowSel, 8'hF7);

        // 4: clear beats a simultaneous write; read-before-write on row 5
        tick();
        wrIndex     = 3'd0;
        wrData      = 8'hFF;
        writeStrobe = 1'b1;
        clearAll    = 1'b1;
        tick();
        writeStrobe = 1'b0;
        clearAll    = 1'b0;
        $display("cycle %0d: clearAll with write row 0 = ff", cyc);
        for (int r = 0; r < 8; r++) begin
            rdIndex = 3'(r);
            tick();
            check_eq($sformatf("t4_clear_row%0d", r), rowRead, 8'h00);
        end
        do_write(3'd5, 8'h5A);
        rdIndex = 3'd5;
        do_write(3'd5, 8'hA5);
        check_eq("t4_rbw_old", rowRead, 8'h5A);
        tick();
        check_eq("t4_rbw_new", rowRead, 8'hA5);
        do_write(3'd6, 8'h3C);

        // 5: asynchronous reset in the middle of row 6 SHOW
        t5 = ((cyc / 80) + 1) * 80 + 65;
        run_to(t5);
        check_eq("t5_pre_sel", rowSel, 8'hBF);
        check_eq("t5_pre_col", colData, 8'h3C);
        resetN = 1'b0;
        #1;
        $display("cycle %0d: reset asserted mid-slot", cyc);
        check_eq("t5_rst_sel", rowSel, 8'hFF);
        check_eq("t5_rst_col", colData, 8'h00);
        check_eq("t5_rst_read", rowRead, 8'h00);
        @(negedge sysClk);
        @(negedge sysClk);
        resetN = 1'b1;
        cyc    = 0;
        $display("cycle %0d: reset released", cyc);
        tick();
        check_eq("t5_c1_sel", rowSel, 8'hFF);
        check_eq("t5_c1_read", rowRead, 8'h00);
        tick();
        check_eq("t5_c2_sel", rowSel, 8'hFE);
        check_eq("t5_c2_col", colData, 8'h00);

        // 6: three frames of one-hot and blanking-gap checks
        blank_run   = 0;
        prev_active = 1'b1;
        while (cyc < 2 + 3 * 8 * SCAN_DIV) begin
            tick();
            check_eq("t6_onehot", ($countones(~rowSel) <= 1), 1'b1);
            check_eq("t6_rowSel", rowSel, exp_sel(cyc));
            check_eq("t6_frameTick", frameTick, exp_tick(cyc));
            if (rowSel == 8'hFF) begin
                blank_run++;
                prev_active = 1'b0;
            end else begin
                if (!prev_active) begin
                    check_eq("t6_blank_gap", (blank_run >= BLANK_CYCLES), 1'b1);
                end
                blank_run   = 0;
                prev_active = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
